// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encoding, size defaults and segment codes
package calc_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        ATUALIZA = 2'd2
    } estado_t;

    localparam int N_BITS_DEF    = 14;
    localparam int N_DIGITOS_DEF = 5;

    // Active-low segments, bit6..bit0 = g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

endpackage

// File: rtl/decod_7seg.sv
// rtl/decod_7seg.sv - combinational BCD digit to active-low 7-segment decoder
module decod_7seg
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/conversor_display.sv
// rtl/conversor_display.sv - binary result to signed 7-segment display via serial double dabble
module conversor_display
    import calc_pkg::*;
#(
    parameter int N_BITS    = N_BITS_DEF,
    parameter int N_DIGITOS = N_DIGITOS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] Y,
    input  logic              sinal,
    input  logic              EN,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5,
    output logic              pronto
);

    localparam int BCD_W = 4 * N_DIGITOS;
    localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    estado_t              state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [N_BITS-1:0]    bin_q, bin_d;
    logic [N_BITS:0]      cap_q, cap_d, last_q, last_d;
    logic                 valid_q, valid_d, en_q, en_d, pronto_q, pronto_d;
    logic [5:0][6:0]      dig_q, dig_d, hex_q, hex_d, new_dig;
    logic [N_DIGITOS-1:0][6:0] seg;

    genvar g;
    generate
        for (g = 0; g < N_DIGITOS; g++) begin : g_dec
            decod_7seg u_dec (
                .bcd (bcd_q[4*g +: 4]),
                .seg (seg[g])
            );
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N_DIGITOS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
    end

    // Leading-zero blanking: scan from the top digit; units digit is always shown
    always_comb begin
        logic lead;
        lead    = 1'b1;
        new_dig = {6{SEG_BLANK}};
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0 || i == 0) begin
                lead = 1'b0;
            end
            new_dig[i] = lead ? SEG_BLANK : seg[i];
        end
        new_dig[5] = (cap_q[0] && cap_q[N_BITS:1] != '0) ? SEG_MINUS : SEG_BLANK;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cap_d    = cap_q;
        last_d   = last_q;
        valid_d  = valid_q;
        pronto_d = pronto_q;
        dig_d    = dig_q;
        en_d     = EN;
        case (state_q)
            OCIOSO: begin
                if (!valid_q || {Y, sinal} != last_q) begin
                    cap_d    = {Y, sinal};
                    bin_d    = Y;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    pronto_d = 1'b0;
                    state_d  = CONVERTE;
                end
            end
            CONVERTE: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ATUALIZA;
                end
            end
            ATUALIZA: begin
                dig_d    = new_dig;
                last_d   = cap_q;
                valid_d  = 1'b1;
                pronto_d = 1'b1;
                state_d  = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
        hex_d = en_q ? dig_d : {6{SEG_BLANK}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OCIOSO;
            cnt_q    <= '0;
            bcd_q    <= '0;
            bin_q    <= '0;
            cap_q    <= '0;
            last_q   <= '0;
            valid_q  <= 1'b0;
            en_q     <= 1'b0;
            pronto_q <= 1'b0;
            dig_q    <= {6{SEG_BLANK}};
            hex_q    <= {6{SEG_BLANK}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cap_q    <= cap_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            en_q     <= en_d;
            pronto_q <= pronto_d;
            dig_q    <= dig_d;
            hex_q    <= hex_d;
        end
    end

    assign HEX0   = hex_q[0];
    assign HEX1   = hex_q[1];
    assign HEX2   = hex_q[2];
    assign HEX3   = hex_q[3];
    assign HEX4   = hex_q[4];
    assign HEX5   = hex_q[5];
    assign pronto = pronto_q;

endmodule

// File: tb/tb_conversor_display.sv
// tb/tb_conversor_display.sv - self-checking bench for conversor_display
module tb_conversor_display;

    typedef logic [5:0][6:0] hexv_t;

    typedef struct {
        int    y;
        bit    s;
        hexv_t exp;
    } vec_t;

    localparam hexv_t ALL_BLANK = {6{7'h7F}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] Y;
    logic        sinal;
    logic        EN;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        pronto;
    hexv_t       hexv;

    int checks   = 0;
    int failures = 0;
    hexv_t exp_q[$];
    vec_t  vecs[8];

    assign hexv = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    always #5 clk = ~clk;

    conversor_display dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Y      (Y),
        .sinal  (sinal),
        .EN     (EN),
        .HEX0   (HEX0),
        .HEX1   (HEX1),
        .HEX2   (HEX2),
        .HEX3   (HEX3),
        .HEX4   (HEX4),
        .HEX5   (HEX5),
        .pronto (pronto)
    );

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic hexv_t model(int y, bit s);
        hexv_t r;
        int    d[5];
        int    msd;
        int    v;
        v   = y;
        msd = 0;
        for (int i = 0; i < 5; i++) begin
            d[i] = v % 10;
            v    = v / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 5; i++) r[i] = (i <= msd) ? seg_of(d[i]) : 7'h7F;
        r[5] = (s && y != 0) ? 7'h3F : 7'h7F;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compare_pop(string name);
        hexv_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s actual=no_expectation required=queued_result", name);
        end else begin
            e = exp_q.pop_front();
            checks--;
            chk(name, 64'(hexv), 64'(e));
        end
    endtask

    // Advance edges until pronto rises; returns the number of edges waited
    task automatic wait_pronto(output int n, output bit changed);
        hexv_t prev;
        prev    = hexv;
        changed = 1'b0;
        n       = 0;
        while (pronto !== 1'b1 && n < 40) begin
            if (hexv !== prev) changed = 1'b1;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_vec(int y, bit s, hexv_t e, string name);
        int n;
        bit changed;
        @(negedge clk);
        Y     = 14'(y);
        sinal = s;
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk({name, "_capture_pronto"}, 64'(pronto), 64'(0));
        wait_pronto(n, changed);
        chk({name, "_latency"}, 64'(n), 64'(15));
        chk({name, "_hold"}, 64'(changed), 64'(0));
        compare_pop({name, "_hex"});
    endtask

    initial begin
        int  n;
        bit  changed;
        int  drops;

        vecs[0] = '{16129, 1'b0, {7'h7F, 7'h79, 7'h02, 7'h79, 7'h24, 7'h10}};
        vecs[1] = '{42,    1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}};
        vecs[2] = '{0,     1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16383, 1'b1, model(16383, 1'b1)};
        vecs[4] = '{9,     1'b0, model(9, 1'b0)};
        vecs[5] = '{10,    1'b1, model(10, 1'b1)};
        vecs[6] = '{1005,  1'b0, model(1005, 1'b0)};
        vecs[7] = '{2400,  1'b0, model(2400, 1'b0)};

        rst_n = 1'b0;
        Y     = '0;
        sinal = 1'b0;
        EN    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hex", 64'(hexv), 64'(ALL_BLANK));
        chk("reset_pronto", 64'(pronto), 64'(0));

        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        repeat (15) @(posedge clk);
        #1;
        chk("first_pronto_e15", 64'(pronto), 64'(0));
        @(posedge clk); #1;
        chk("first_pronto_e16", 64'(pronto), 64'(1));
        compare_pop("first_hex_e16");

        foreach (vecs[i]) run_vec(vecs[i].y, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

        drops = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (pronto !== 1'b1) drops++;
        end
        chk("no_reconversion", 64'(drops), 64'(0));

        // Input change mid-conversion is ignored, then picked up afterwards
        @(negedge clk);
        Y     = 14'd100;
        sinal = 1'b0;
        exp_q.push_back({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        Y = 14'd7;
        exp_q.push_back(model(7, 1'b0));
        #6;
        wait_pronto(n, changed);
        chk("mid_change_first_done", 64'(pronto), 64'(1));
        compare_pop("mid_change_hex100");
        @(posedge clk); #1;
        chk("mid_change_drop", 64'(pronto), 64'(0));
        wait_pronto(n, changed);
        chk("mid_change_latency", 64'(n), 64'(15));
        compare_pop("mid_change_hex7");

        @(negedge clk);
        EN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("en_off_hex", 64'(hexv), 64'(ALL_BLANK));
        chk("en_off_pronto", 64'(pronto), 64'(1));
        @(negedge clk);
        EN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("en_on_hex", 64'(hexv), 64'(model(7, 1'b0)));
        chk("en_on_pronto", 64'(pronto), 64'(1));

        // Reset in the middle of a conversion
        @(negedge clk);
        Y     = 14'd16383;
        sinal = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_hex", 64'(hexv), 64'(ALL_BLANK));
        chk("midrst_pronto", 64'(pronto), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(16383, 1'b1));
        wait_pronto(n, changed);
        chk("midrst_latency", 64'(n), 64'(16));
        compare_pop("midrst_hex");

        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
